riscv_mem_arbiter: RTL and testbench
====================================

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 Parameter p_addr_sz, default 32: request address width.
REQ-002 Parameter p_data_sz, default 32: request/response data width.
REQ-003 Parameter p_max_outst, default 4: maximum in-flight memory requests (power of 2, at least 2).
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req0_msg  in  67  port 0 (instruction) request: type[66], addr[65:34], len[33:32], data[31:0].
REQ-007 req0_val  in  1  port 0 request valid.
REQ-008 req0_rdy  out  1  port 0 request accepted this cycle.
REQ-009 req1_msg / req1_val / req1_rdy  in/in/out  67/1/1  port 1 (data) request, same format and handshake.
REQ-010 resp0_msg  out  35  port 0 response: type[34], len[33:32], data[31:0].
REQ-011 resp0_val  out  1  port 0 response valid; requesters always accept.
REQ-012 resp1_msg / resp1_val  out/out  35/1  port 1 response.
REQ-013 memreq_msg / memreq_val / memreq_rdy  out/out/in  67/1/1  shared single-port memory request.
REQ-014 memresp_msg / memresp_val  in/in  35/1  memory response, in order, no backpressure.
REQ-015 outst_cnt  out  $clog2(p_max_outst)+1  current in-flight count.
REQ-016 err_orphan  out  1  sticky flag: response arrived with nothing in flight.

Function
REQ-017 Transfer fires on a port when val && rdy are both high in the same cycle.
REQ-018 full = (outst_cnt == p_max_outst), evaluated on the registered count; no bypass for a same-cycle pop.
REQ-019 memreq_val = (req0_val || req1_val) && !full, combinational.
REQ-020 Grant when one port is valid: that port.
REQ-021 Grant when both ports are valid: the port selected by the 1-bit round-robin pointer prio.
REQ-022 memreq_msg = granted port's msg, unmodified.
REQ-023 reqN_rdy = (grant == N) && memreq_rdy && !full; the non-granted port's rdy is 0.
REQ-024 Grant is combinational; no req-to-memreq latency.
REQ-025 On memory fire: push the granted port id to the tag FIFO (depth p_max_outst); set prio to the other port.
REQ-026 prio is unchanged in any cycle without a memory fire.
REQ-027 On memresp_val with the FIFO non-empty: pop the head; assert resp<head>_val for exactly that cycle.
REQ-028 resp0_msg and resp1_msg = memresp_msg (broadcast); only the val signals are steered.
REQ-029 Response latency through the block is 0 cycles (combinational steering).
REQ-030 Simultaneous push and pop: outst_cnt unchanged; FIFO pointers both advance, wrap modulo p_max_outst.
REQ-031 memresp_val with the FIFO empty: no respN_val; set err_orphan, held until reset; count stays 0.
REQ-032 memreq_rdy low: no fire, no push, no prio change; granted port sees rdy=0 and holds its msg.
REQ-033 Once asserted, a requester's val and msg remain stable until fire; the arbiter does not re-check this.

Reset
REQ-034 While reset=0: outst_cnt=0, FIFO pointers=0, prio=0 (port 0 first), err_orphan=0.
REQ-035 While reset=0: all rdy/val outputs are forced 0.
REQ-036 Reset mid-operation discards in-flight tags; the memory is reset in the same domain by the system.

Structure
REQ-037 A shared package holds: message field offsets, widths 67/35, port-id encoding (0=imem, 1=dmem).
REQ-038 One sub-module, riscv_mem_arbiter_tagq: a p_max_outst x 1-bit FIFO with push/pop/full/empty/count.

Verification
REQ-039 Single port: req0 read addr 0x100, mem latency 0 -> memreq fires same cycle; resp0_val one cycle later; resp1_val never asserts.
REQ-040 Contention: req0 and req1 both valid every cycle for 8 cycles, memreq_rdy=1 -> grants alternate 0,1,0,1...; each port receives 4 responses in issue order.
REQ-041 Full: p_max_outst=4, memresp held off -> after 4 fires memreq_val=0 and both rdy=0, outst_cnt=4; one response -> count=3 next cycle and a grant resumes.
REQ-042 Simultaneous push/pop at count=2 -> count stays 2; response goes to the FIFO head port, not the port being pushed.
REQ-043 Orphan: memresp_val pulsed at count=0 -> err_orphan=1 and sticky; no respN_val.
REQ-044 Async reset asserted mid-burst with count=3 -> all outputs 0 immediately; after release prio=0 and count=0.

Source files
------------

// File: rtl/riscv_mem_arbiter_pkg.sv
// riscv_mem_arbiter_pkg: shared message layout, port ids and message builders
package riscv_mem_arbiter_pkg;
  localparam int req_msg_w = 67;
  localparam int resp_msg_w = 35;
  localparam int req_type_bit = 66;
  localparam int req_addr_lsb = 34;
  localparam int req_len_lsb = 32;
  localparam int resp_type_bit = 34;
  localparam int resp_len_lsb = 32;
  localparam int data_lsb = 0;
  typedef enum logic {port_imem = 1'b0, port_dmem = 1'b1} port_e;
  function automatic logic [req_msg_w-1:0] mk_req(input logic typ, input logic [31:0] addr,
                                                  input logic [1:0] len, input logic [31:0] data);
    return {typ, addr, len, data};
  endfunction
  function automatic logic [resp_msg_w-1:0] mk_resp(input logic typ, input logic [1:0] len,
                                                    input logic [31:0] data);
    return {typ, len, data};
  endfunction
endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// riscv_mem_arbiter_if: requester, memory and status signals of the arbiter
interface riscv_mem_arbiter_if #(
  parameter int p_addr_sz = 32,
  parameter int p_data_sz = 32,
  parameter int p_max_outst = 4
);
  localparam int req_w = p_addr_sz + p_data_sz + 3;
  localparam int resp_w = p_data_sz + 3;
  logic [req_w-1:0] req0_msg, req1_msg, memreq_msg;
  logic req0_val, req0_rdy, req1_val, req1_rdy, memreq_val, memreq_rdy;
  logic [resp_w-1:0] resp0_msg, resp1_msg, memresp_msg;
  logic resp0_val, resp1_val, memresp_val;
  logic [$clog2(p_max_outst):0] outst_cnt;
  logic err_orphan;
  modport slave (
    input req0_msg, req0_val, req1_msg, req1_val, memreq_rdy, memresp_msg, memresp_val,
    output req0_rdy, req1_rdy, memreq_msg, memreq_val, resp0_msg, resp0_val,
    output resp1_msg, resp1_val, outst_cnt, err_orphan
  );
  modport master (
    output req0_msg, req0_val, req1_msg, req1_val, memreq_rdy, memresp_msg, memresp_val,
    input req0_rdy, req1_rdy, memreq_msg, memreq_val, resp0_msg, resp0_val,
    input resp1_msg, resp1_val, outst_cnt, err_orphan
  );
endinterface

// File: rtl/riscv_mem_arbiter_tagq.sv
// riscv_mem_arbiter_tagq: FIFO of issuing-port ids for in-flight memory requests
module riscv_mem_arbiter_tagq
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int p_max_outst = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  port_e din,
  output port_e head,
  output logic full,
  output logic empty,
  output logic [$clog2(p_max_outst):0] count
);
  localparam int ptr_w = $clog2(p_max_outst);
  logic [p_max_outst-1:0] mem;
  logic [ptr_w-1:0] wr_ptr, rd_ptr;
  // tag storage and pointers; power-of-2 depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (ptr_w+1)'(push) - (ptr_w+1)'(pop);
    end
  end
  // status flags and head tag
  always_comb begin
    head = port_e'(mem[rd_ptr]);
    full = count == (ptr_w+1)'(p_max_outst);
    empty = count == '0;
  end
endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: round-robin two-port arbiter onto one in-order memory port
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int p_addr_sz = 32,
  parameter int p_data_sz = 32,
  parameter int p_max_outst = 4
) (
  input logic clk,
  input logic reset,
  riscv_mem_arbiter_if.slave bus
);
  logic full, empty, grant, prio, fire, pop, err;
  port_e head;
  logic [$clog2(p_max_outst):0] count;
  logic [p_addr_sz+p_data_sz+2:0] grant_msg;
  logic [p_data_sz+2:0] resp_msg;
  riscv_mem_arbiter_tagq #(.p_max_outst(p_max_outst)) u_tagq (
    .clk(clk), .reset(reset), .push(fire), .pop(pop), .din(port_e'(grant)),
    .head(head), .full(full), .empty(empty), .count(count)
  );
  // grant, handshakes and response steering; everything is forced idle during reset
  always_comb begin
    grant = bus.req1_val && (!bus.req0_val || prio);
    grant_msg = grant ? bus.req1_msg : bus.req0_msg;
    resp_msg = bus.memresp_msg;
    bus.memreq_msg = grant_msg;
    bus.memreq_val = reset && (bus.req0_val || bus.req1_val) && !full;
    bus.req0_rdy = reset && !grant && bus.memreq_rdy && !full;
    bus.req1_rdy = reset && grant && bus.memreq_rdy && !full;
    fire = bus.memreq_val && bus.memreq_rdy;
    pop = reset && bus.memresp_val && !empty;
    bus.resp0_val = pop && head == port_imem;
    bus.resp1_val = pop && head == port_dmem;
    bus.resp0_msg = resp_msg;
    bus.resp1_msg = resp_msg;
    bus.outst_cnt = count;
    bus.err_orphan = err;
  end
  // round-robin pointer moves to the other port only when a request issues
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prio <= 1'b0;
    else if (fire) prio <= !grant;
  end
  // sticky flag for a memory response with no request in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= 1'b0;
    else if (bus.memresp_val && empty) err <= 1'b1;
  end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed checks of arbitration, tag steering, full, orphan and reset
module tb_riscv_mem_arbiter;
  import riscv_mem_arbiter_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  int n0 = 0;
  int n1 = 0;
  logic [66:0] m0, m1;
  logic [34:0] r0;
  riscv_mem_arbiter_if bus ();
  riscv_mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chkc(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chkv(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    m0 = mk_req(1'b0, 32'h100, 2'd0, 32'h0);
    m1 = mk_req(1'b1, 32'h1000, 2'd2, 32'h55);
    r0 = mk_resp(1'b0, 2'd0, 32'hdeadbeef);
    reset = 1'b0;
    bus.req0_msg = '0; bus.req1_msg = '0; bus.req0_val = 1'b0; bus.req1_val = 1'b0;
    bus.memreq_rdy = 1'b0; bus.memresp_msg = '0; bus.memresp_val = 1'b0;
    #2;
    bus.req0_val = 1'b1; bus.memreq_rdy = 1'b1; bus.memresp_val = 1'b1;
    #1;
    chkb("rst_memreq_val", bus.memreq_val, 1'b0);
    chkb("rst_rdy0", bus.req0_rdy, 1'b0);
    chkb("rst_resp0_val", bus.resp0_val, 1'b0);
    chkc("rst_cnt", bus.outst_cnt, 3'd0);
    chkb("rst_err", bus.err_orphan, 1'b0);
    bus.req0_val = 1'b0; bus.memresp_val = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    // single port, memory latency 0
    bus.req0_msg = m0; bus.req0_val = 1'b1; bus.memreq_rdy = 1'b1;
    #1;
    chkb("t1_memreq_val", bus.memreq_val, 1'b1);
    chkv("t1_memreq_msg", bus.memreq_msg, m0);
    chkb("t1_rdy0", bus.req0_rdy, 1'b1);
    chkb("t1_rdy1", bus.req1_rdy, 1'b0);
    cyc();
    bus.req0_val = 1'b0;
    chkc("t1_cnt", bus.outst_cnt, 3'd1);
    bus.memresp_msg = r0; bus.memresp_val = 1'b1;
    #1;
    chkb("t1_resp0_val", bus.resp0_val, 1'b1);
    chkb("t1_resp1_val", bus.resp1_val, 1'b0);
    chkv("t1_resp0_msg", 67'(bus.resp0_msg), 67'(r0));
    cyc();
    bus.memresp_val = 1'b0;
    chkc("t1_cnt_done", bus.outst_cnt, 3'd0);
    // fresh reset so contention starts with port 0 priority
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    // contention: both valid 8 cycles, responses follow one cycle behind
    bus.req1_msg = m1;
    for (int i = 0; i < 9; i++) begin
      bus.req0_val = i < 8; bus.req1_val = i < 8;
      bus.memresp_val = i > 0; bus.memresp_msg = mk_resp(1'b0, 2'd0, 32'(i - 1));
      #1;
      if (i < 8) chkv("t2_grant_msg", bus.memreq_msg, (i % 2 == 1) ? m1 : m0);
      if (i > 0) begin
        chkb("t2_resp0_val", bus.resp0_val, (i - 1) % 2 == 0);
        chkb("t2_resp1_val", bus.resp1_val, (i - 1) % 2 == 1);
        n0 += int'(bus.resp0_val);
        n1 += int'(bus.resp1_val);
      end
      cyc();
    end
    chkc("t2_n0", 3'(n0), 3'd4);
    chkc("t2_n1", 3'(n1), 3'd4);
    chkc("t2_cnt", bus.outst_cnt, 3'd0);
    // full: four fires with responses held off
    bus.memresp_val = 1'b0; bus.req0_val = 1'b1; bus.req1_val = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chkc("t3_cnt_full", bus.outst_cnt, 3'd4);
    chkb("t3_memreq_val_full", bus.memreq_val, 1'b0);
    chkb("t3_rdy0_full", bus.req0_rdy, 1'b0);
    chkb("t3_rdy1_full", bus.req1_rdy, 1'b0);
    bus.memresp_val = 1'b1;
    #1;
    chkb("t3_resp0_val", bus.resp0_val, 1'b1);
    chkb("t3_no_bypass", bus.memreq_val, 1'b0);
    cyc();
    bus.memresp_val = 1'b0;
    chkc("t3_cnt_after_pop", bus.outst_cnt, 3'd3);
    chkb("t3_memreq_val_resume", bus.memreq_val, 1'b1);
    chkb("t3_rdy0_resume", bus.req0_rdy, 1'b1);
    bus.req0_val = 1'b0; bus.req1_val = 1'b0;
    // tags in flight now: 1,0,1 (head first)
    bus.memresp_val = 1'b1;
    #1;
    chkb("t4_resp1_head", bus.resp1_val, 1'b1);
    cyc();
    chkc("t4_cnt2", bus.outst_cnt, 3'd2);
    bus.req1_val = 1'b1;
    #1;
    chkb("t4_rdy1", bus.req1_rdy, 1'b1);
    chkb("t4_resp0_head", bus.resp0_val, 1'b1);
    chkb("t4_resp1_not_pushed", bus.resp1_val, 1'b0);
    cyc();
    bus.req1_val = 1'b0;
    chkc("t4_cnt_same", bus.outst_cnt, 3'd2);
    #1;
    chkb("t4_drain_a", bus.resp1_val, 1'b1);
    cyc();
    chkb("t4_drain_b", bus.resp1_val, 1'b1);
    cyc();
    bus.memresp_val = 1'b0;
    chkc("t4_cnt_empty", bus.outst_cnt, 3'd0);
    // memory not ready: no fire
    bus.req0_msg = m0; bus.req0_val = 1'b1; bus.memreq_rdy = 1'b0;
    #1;
    chkb("t5_memreq_val", bus.memreq_val, 1'b1);
    chkb("t5_rdy0", bus.req0_rdy, 1'b0);
    cyc();
    chkc("t5_cnt", bus.outst_cnt, 3'd0);
    bus.req0_val = 1'b0; bus.memreq_rdy = 1'b1;
    // orphan response
    bus.memresp_val = 1'b1;
    #1;
    chkb("t6_resp0_val", bus.resp0_val, 1'b0);
    chkb("t6_resp1_val", bus.resp1_val, 1'b0);
    cyc();
    bus.memresp_val = 1'b0;
    chkb("t6_err", bus.err_orphan, 1'b1);
    chkc("t6_cnt", bus.outst_cnt, 3'd0);
    cyc();
    chkb("t6_err_sticky", bus.err_orphan, 1'b1);
    // async reset mid-burst at count 3
    bus.req0_val = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chkc("t7_cnt3", bus.outst_cnt, 3'd3);
    bus.req1_val = 1'b1; bus.memresp_val = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chkc("t7_rst_cnt", bus.outst_cnt, 3'd0);
    chkb("t7_rst_memreq_val", bus.memreq_val, 1'b0);
    chkb("t7_rst_rdy0", bus.req0_rdy, 1'b0);
    chkb("t7_rst_rdy1", bus.req1_rdy, 1'b0);
    chkb("t7_rst_resp0", bus.resp0_val, 1'b0);
    chkb("t7_rst_resp1", bus.resp1_val, 1'b0);
    chkb("t7_rst_err", bus.err_orphan, 1'b0);
    bus.memresp_val = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chkv("t7_prio0_msg", bus.memreq_msg, m0);
    chkb("t7_prio0_rdy0", bus.req0_rdy, 1'b1);
    chkc("t7_cnt_after", bus.outst_cnt, 3'd0);
    bus.req0_val = 1'b0; bus.req1_val = 1'b0;
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
